switch_arbiter: RTL and testbench

//  Arbitration and sequencing controller for the 4-port switch datapath.
//  - Each input port posts one 8-bit-address/8-bit-data beat; the address picks the destination output port.
//  - One round-robin arbiter per output port selects one requesting input, then holds that output busy until the receiver accepts.
//  - Sits between the input-port logic (valid_in/addr_in) and the output mux (valid_out/rcv_rdy/data_rd).

---
 rtl/switch_pkg.sv | 37 +++
 rtl/switch_out_arb.sv | 115 +++++++++++
 rtl/switch_arbiter.sv | 84 ++++++++
 tb/tb_switch_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// ---------------------------------------------------------------------------
// switch_pkg
//   Shared types and constants for the 4-port switch arbitration logic.
//   NPORTS      : number of input and output ports (fixed at 4)
//   TIMEOUT_W   : width of the per-output transfer timeout counter
//   port_idx_t  : 2-bit port index
//   arb_state_e : per-output arbiter state {IDLE, GRANT, XFER}
//   rr_pick     : round-robin winner search starting at a pointer
// ---------------------------------------------------------------------------
package switch_pkg;

  localparam int NPORTS    = 4;
  localparam int TIMEOUT_W = 8;

  typedef logic [1:0] port_idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    XFER  = 2'd2
  } arb_state_e;

  // First set bit of req at or after ptr, wrapping 3->0. Scanning from the
  // farthest offset down lets the nearest requester overwrite the result.
  function automatic port_idx_t rr_pick(input logic [NPORTS-1:0] req,
                                        input port_idx_t         ptr);
    port_idx_t idx;
    port_idx_t win;
    win = ptr;
    for (int k = NPORTS - 1; k >= 0; k--) begin
      idx = ptr + port_idx_t'(k);
      if (req[idx]) win = idx;
    end
    return win;
  endfunction

endpackage

// File: rtl/switch_out_arb.sv
// ---------------------------------------------------------------------------
// switch_out_arb
//   One output port's arbiter: IDLE/GRANT/XFER FSM, round-robin pointer and,
//   when ARB_TIMEOUT_EN is defined, an 8-bit transfer timeout counter.
//   Ports:
//     clk          : clock, posedge
//     reset        : asynchronous active-low reset
//     req[3:0]     : inputs currently requesting this output
//     rcv_rdy      : receiver ready (only looked at in IDLE)
//     data_rd      : receiver read strobe, ends XFER
//     grant[3:0]   : one-hot pulse to the winning input during GRANT
//     sel          : latched winner index (holds in IDLE)
//     valid_out    : high for the whole XFER state
//     timeout_err  : sticky timeout flag (0 unless ARB_TIMEOUT_EN)
//   Macro: ARB_TIMEOUT_EN enables the forced release after TIMEOUT+1 XFER cycles.
// ---------------------------------------------------------------------------
module switch_out_arb
  import switch_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NPORTS-1:0] req,
  input  logic              rcv_rdy,
  input  logic              data_rd,
  output logic [NPORTS-1:0] grant,
  output port_idx_t         sel,
  output logic              valid_out,
  output logic              timeout_err
);

  arb_state_e state_q, state_d;
  port_idx_t  ptr_q, ptr_d;
  port_idx_t  sel_q, sel_d;
  logic       release_c;

`ifdef ARB_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(TIMEOUT);

  logic [TIMEOUT_W-1:0] cnt_q;
  logic                 err_q;
  logic                 expire_c;

  // data_rd on the limit cycle takes priority: normal release, no error.
  assign expire_c = (state_q == XFER) && !data_rd && (cnt_q == LIMIT);
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    grant     = '0;
    valid_out = 1'b0;
    release_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rcv_rdy && (|req)) begin
          state_d = GRANT;
          sel_d   = rr_pick(req, ptr_q);
        end
      end
      GRANT: begin
        grant[sel_q] = 1'b1;
        state_d      = XFER;
      end
      XFER: begin
        valid_out = 1'b1;
`ifdef ARB_TIMEOUT_EN
        release_c = data_rd || expire_c;
`else
        release_c = data_rd;
`endif
        if (release_c) begin
          state_d = IDLE;
          ptr_d   = sel_q + port_idx_t'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Counter is zero on the first XFER cycle and counts XFER cycles after it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == GRANT)     cnt_q <= '0;
      else if (state_q == XFER) cnt_q <= cnt_q + 1'b1;
      if (expire_c)             err_q <= 1'b1;
    end
  end

  assign timeout_err = err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign sel = sel_q;

endmodule

// File: rtl/switch_arbiter.sv
// ---------------------------------------------------------------------------
// switch_arbiter
//   Arbitration and sequencing controller for the 4-port switch datapath.
//   Decodes each input's destination field into per-output request vectors,
//   runs one round-robin arbiter per output and merges their grants.
//   Parameters:
//     DEST_LSB : bit position of the 2-bit destination field in each address byte
//     TIMEOUT  : XFER timeout limit (ARB_TIMEOUT_EN builds only)
//   Ports:
//     clk, reset        : clock (posedge), asynchronous active-low reset
//     valid_in[3:0]     : per-input request, held until its grant pulse
//     addr_in[31:0]     : 4 address bytes, byte i for input i
//     rcv_rdy[3:0]      : per-output receiver ready
//     data_rd[3:0]      : per-output read strobe ending the transfer
//     grant[3:0]        : per-input one-cycle grant pulse
//     out_sel[7:0]      : 2-bit source index per output
//     valid_out[3:0]    : per-output transfer active
//     timeout_err[3:0]  : per-output sticky timeout flag
//   Macro: ARB_TIMEOUT_EN enables per-output transfer timeouts.
// ---------------------------------------------------------------------------
module switch_arbiter
  import switch_pkg::*;
#(
  parameter int unsigned DEST_LSB = 0,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NPORTS-1:0]   valid_in,
  input  logic [8*NPORTS-1:0] addr_in,
  input  logic [NPORTS-1:0]   rcv_rdy,
  input  logic [NPORTS-1:0]   data_rd,
  output logic [NPORTS-1:0]   grant,
  output logic [2*NPORTS-1:0] out_sel,
  output logic [NPORTS-1:0]   valid_out,
  output logic [NPORTS-1:0]   timeout_err
);

  port_idx_t         dest     [NPORTS];
  logic [NPORTS-1:0] req_arb  [NPORTS];
  logic [NPORTS-1:0] grant_arb[NPORTS];
  port_idx_t         sel_arb  [NPORTS];

  // Only the destination field of each address byte is consumed here.
  logic unused_addr;
  assign unused_addr = ^addr_in;

  for (genvar i = 0; i < NPORTS; i++) begin : g_dest
    assign dest[i] = addr_in[8*i+DEST_LSB +: 2];
  end

  always_comb begin
    for (int o = 0; o < NPORTS; o++) begin
      for (int i = 0; i < NPORTS; i++) begin
        req_arb[o][i] = valid_in[i] && (dest[i] == port_idx_t'(o));
      end
    end
  end

  for (genvar o = 0; o < NPORTS; o++) begin : g_arb
    switch_out_arb #(
      .TIMEOUT (TIMEOUT)
    ) u_arb (
      .clk         (clk),
      .reset       (reset),
      .req         (req_arb[o]),
      .rcv_rdy     (rcv_rdy[o]),
      .data_rd     (data_rd[o]),
      .grant       (grant_arb[o]),
      .sel         (sel_arb[o]),
      .valid_out   (valid_out[o]),
      .timeout_err (timeout_err[o])
    );
    assign out_sel[2*o +: 2] = sel_arb[o];
  end

  // An input has exactly one destination, so the OR never merges two grants
  // for the same input.
  always_comb begin
    grant = '0;
    for (int o = 0; o < NPORTS; o++) grant = grant | grant_arb[o];
  end

endmodule

// File: tb/tb_switch_arbiter.sv
// ---------------------------------------------------------------------------
// tb_switch_arbiter
//   Directed bench for switch_arbiter. Stimulus pushes expected grant events
//   (cycle, grant vector, masked out_sel) into a queue; a monitor on the
//   falling edge pops and compares every grant the DUT issues.
// ---------------------------------------------------------------------------
module tb_switch_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TMO = 4;
`else
  localparam int unsigned TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  valid_in = '0;
  logic [31:0] addr_in = '0;
  logic [3:0]  rcv_rdy = '0;
  logic [3:0]  data_rd = '0;
  logic [3:0]  grant;
  logic [7:0]  out_sel;
  logic [3:0]  valid_out;
  logic [3:0]  timeout_err;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         cyc;
    logic [3:0] grant;
    logic [7:0] sel;
    logic [7:0] mask;
  } exp_t;

  exp_t sb[$];

  switch_arbiter #(
    .DEST_LSB (0),
    .TIMEOUT  (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .valid_in    (valid_in),
    .addr_in     (addr_in),
    .rcv_rdy     (rcv_rdy),
    .data_rd     (data_rd),
    .grant       (grant),
    .out_sel     (out_sel),
    .valid_out   (valid_out),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input int c, input logic [3:0] g,
                              input logic [7:0] s, input logic [7:0] m);
    exp_t e;
    e.cyc = c; e.grant = g; e.sel = s; e.mask = m;
    sb.push_back(e);
  endtask

  task automatic drain(input string name);
    check(name, sb.size(), 0);
    sb.delete();
  endtask

  // Monitor: every non-zero grant must match the oldest expected event.
  always @(negedge clk) begin
    exp_t e;
    if (reset && grant != 4'b0000) begin
      if (sb.size() == 0) begin
        check("unexpected_grant", {28'b0, grant}, 32'h0);
      end else begin
        e = sb.pop_front();
        n_cmp++;
        if (cyc != e.cyc || grant !== e.grant || (out_sel & e.mask) !== (e.sel & e.mask)) begin
          n_bad++;
          $display("FAIL grant_event: got cyc=%0d grant=%b out_sel=%b, required cyc=%0d grant=%b out_sel=%b (mask %b)",
                   cyc, grant, out_sel, e.cyc, e.grant, e.sel, e.mask);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;

    // Reset state
    #2 reset = 1'b0;
    #1;
    check("rst_grant", {28'b0, grant}, 32'h0);
    check("rst_out_sel", {24'b0, out_sel}, 32'h0);
    check("rst_valid_out", {28'b0, valid_out}, 32'h0);
    check("rst_timeout_err", {28'b0, timeout_err}, 32'h0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // 1. Single request: input 0 -> output 2
    t0 = cyc;
    rcv_rdy  = 4'b1111;
    addr_in  = 32'h0000_0002;
    valid_in = 4'b0001;
    expect_grant(t0 + 1, 4'b0001, 8'b00_00_00_00, 8'b0011_0000);
    tick();
    valid_in = 4'b0000;
    tick();
    check("t1_vout_c2", {28'b0, valid_out}, 32'h4);
    tick();
    check("t1_vout_c3", {28'b0, valid_out}, 32'h4);
    tick();
    check("t1_vout_c4", {28'b0, valid_out}, 32'h4);
    data_rd = 4'b0100;
    tick();
    data_rd = 4'b0000;
    check("t1_vout_c5", {28'b0, valid_out}, 32'h0);
    drain("t1_pending");
    tick();

    // 2. Round-robin: all inputs -> output 1, read on first XFER cycle
    t0 = cyc;
    addr_in  = 32'h0101_0101;
    valid_in = 4'b1111;
    data_rd  = 4'b0010;
    expect_grant(t0 + 1,  4'b0001, 8'b0000_0000, 8'b0000_1100);
    expect_grant(t0 + 4,  4'b0010, 8'b0000_0100, 8'b0000_1100);
    expect_grant(t0 + 7,  4'b0100, 8'b0000_1000, 8'b0000_1100);
    expect_grant(t0 + 10, 4'b1000, 8'b0000_1100, 8'b0000_1100);
    expect_grant(t0 + 13, 4'b0001, 8'b0000_0000, 8'b0000_1100);
    repeat (13) tick();
    valid_in = 4'b0000;
    tick();
    check("t2_vout_xfer", {28'b0, valid_out}, 32'h2);
    tick();
    data_rd = 4'b0000;
    check("t2_vout_idle", {28'b0, valid_out}, 32'h0);
    drain("t2_pending");
    tick();

    // 3. Parallel outputs: inputs 0..3 -> outputs 3,2,1,0
    t0 = cyc;
    addr_in  = 32'h0001_0203;
    valid_in = 4'b1111;
    expect_grant(t0 + 1, 4'b1111, 8'b00_01_10_11, 8'hFF);
    tick();
    valid_in = 4'b0000;
    tick();
    check("t3_vout_all", {28'b0, valid_out}, 32'hF);
    check("t3_out_sel", {24'b0, out_sel}, 32'h1B);
    data_rd = 4'b1111;
    tick();
    data_rd = 4'b0000;
    check("t3_vout_idle", {28'b0, valid_out}, 32'h0);
    drain("t3_pending");
    tick();

    // 4. Back-pressure: input 2 -> output 0 while rcv_rdy[0]=0
    rcv_rdy  = 4'b1110;
    addr_in  = 32'h0000_0000;
    valid_in = 4'b0100;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t4_no_grant", {28'b0, grant}, 32'h0);
    end
    t0 = cyc;
    rcv_rdy = 4'b1111;
    expect_grant(t0 + 1, 4'b0100, 8'b0000_0010, 8'b0000_0011);
    tick();
    valid_in = 4'b0000;
    tick();
    check("t4_vout", {28'b0, valid_out}, 32'h1);
    data_rd = 4'b0001;
    tick();
    data_rd = 4'b0000;
    check("t4_vout_idle", {28'b0, valid_out}, 32'h0);
    drain("t4_pending");
    tick();

    // 5. Reset during an output-3 transfer from input 1
    t0 = cyc;
    addr_in  = 32'h0000_0300;
    valid_in = 4'b0010;
    expect_grant(t0 + 1, 4'b0010, 8'b01_00_00_00, 8'b1100_0000);
    tick();
    valid_in = 4'b0000;
    tick();
    check("t5_vout_xfer", {28'b0, valid_out}, 32'h8);
    #2 reset = 1'b0;
    #1;
    check("t5_vout_async", {28'b0, valid_out}, 32'h0);
    check("t5_sel_async", {24'b0, out_sel}, 32'h0);
    drain("t5_pending");
    tick();
    reset = 1'b1;
    tick();
    // Pointer of output 1 was 3 before reset; after reset input 0 must win.
    t0 = cyc;
    addr_in  = 32'h0101_0101;
    valid_in = 4'b1111;
    expect_grant(t0 + 1, 4'b0001, 8'b0000_0000, 8'b0000_1100);
    tick();
    valid_in = 4'b0000;
    data_rd  = 4'b0010;
    tick();
    tick();
    data_rd = 4'b0000;
    check("t5_vout_idle", {28'b0, valid_out}, 32'h0);
    drain("t5b_pending");
    tick();

    // 6. No read strobe after a grant: input 0 -> output 0
    t0 = cyc;
    addr_in  = 32'h0000_0000;
    valid_in = 4'b0001;
    expect_grant(t0 + 1, 4'b0001, 8'b0000_0000, 8'b0000_0011);
    tick();
    valid_in = 4'b0000;
    repeat (5) tick();
    check("t6_vout_c6", {28'b0, valid_out}, 32'h1);
    tick();
`ifdef ARB_TIMEOUT_EN
    check("t6_vout_c7", {28'b0, valid_out}, 32'h0);
    check("t6_err_c7", {28'b0, timeout_err}, 32'h1);
`else
    check("t6_vout_c7", {28'b0, valid_out}, 32'h1);
    check("t6_err_c7", {28'b0, timeout_err}, 32'h0);
`endif
    repeat (3) tick();
`ifdef ARB_TIMEOUT_EN
    check("t6_err_sticky", {28'b0, timeout_err}, 32'h1);
`else
    check("t6_vout_wait", {28'b0, valid_out}, 32'h1);
    check("t6_err_none", {28'b0, timeout_err}, 32'h0);
`endif
    data_rd = 4'b0001;
    tick();
    data_rd = 4'b0000;
    check("t6_vout_final", {28'b0, valid_out}, 32'h0);
    drain("t6_pending");
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
